// File: rtl/exe_muldiv.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers for the EXE stage.
// Optional `MULDIV_EARLY_OUT_EN ends a multiply once no multiplier bits remain.
module exe_muldiv #(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            is_div_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic [63:0]     acc_q;
    logic [63:0]     mcand_q;
    logic [31:0]     opa_q;   // divide: dividend shifting out, quotient shifting in
    logic [31:0]     opb_q;   // multiply: multiplier shifting right; divide: divisor
    logic [31:0]     rem_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic            done_q;

    logic            is_mul;
    logic            is_div;
    logic            is_signed;
    logic [31:0]     a_abs;
    logic [31:0]     b_abs;
    logic [63:0]     acc_sum;
    logic [32:0]     rem_shift;
    logic            rem_ge;
    logic [31:0]     rem_sub;
    logic [31:0]     rem_d;
    logic            cnt_last;
    logic            mul_last;
    logic [63:0]     prod_fix;
    logic [31:0]     quo_fix;
    logic [31:0]     rem_fix;

    always_comb begin
        is_mul    = (op == OpMult) || (op == OpMultu);
        is_div    = (op == OpDiv) || (op == OpDivu);
        is_signed = (op == OpMult) || (op == OpDiv);
        a_abs     = (is_signed && A[31]) ? -A : A;
        b_abs     = (is_signed && B[31]) ? -B : B;
    end

    always_comb begin
        acc_sum   = acc_q + (opb_q[0] ? mcand_q : 64'd0);
        rem_shift = {rem_q, opa_q[31]};
        rem_ge    = rem_shift >= {1'b0, opb_q};
        // Exact whenever rem_ge holds, since the true difference is below 2^32.
        rem_sub   = rem_shift[31:0] - opb_q;
        rem_d     = rem_ge ? rem_sub : rem_shift[31:0];
        cnt_last  = cnt_q == CntW'(MUL_CYCLES - 1);
`ifdef MULDIV_EARLY_OUT_EN
        mul_last  = cnt_last || (opb_q[31:1] == 31'd0);
`else
        mul_last  = cnt_last;
`endif
        prod_fix  = neg_quo_q ? -acc_q : acc_q;
        quo_fix   = neg_quo_q ? -opa_q : opa_q;
        rem_fix   = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (op == OpMthi) begin
                                hi_q <= A;
                            end else if (op == OpMtlo) begin
                                lo_q <= A;
                            end else if (is_mul || is_div) begin
                                is_div_q <= is_div;
                                cnt_q    <= '0;
                                acc_q    <= '0;
                                mcand_q  <= {32'd0, a_abs};
                                opb_q    <= b_abs;
                                if (is_div && (B == 32'd0)) begin
                                    // Divide by zero: preload the fixed result, skip CALC.
                                    opa_q     <= '1;
                                    rem_q     <= A;
                                    neg_quo_q <= 1'b0;
                                    neg_rem_q <= 1'b0;
                                    state_q   <= StFix;
                                end else begin
                                    opa_q     <= a_abs;
                                    rem_q     <= '0;
                                    neg_quo_q <= is_signed && (A[31] ^ B[31]);
                                    neg_rem_q <= is_signed && A[31];
                                    state_q   <= StCalc;
                                end
                            end
                        end
                    end
                    StCalc: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (is_div_q) begin
                            opa_q <= {opa_q[30:0], rem_ge};
                            rem_q <= rem_d;
                            if (cnt_last) state_q <= StFix;
                        end else begin
                            acc_q   <= acc_sum;
                            mcand_q <= mcand_q << 1;
                            opb_q   <= opb_q >> 1;
                            if (mul_last) state_q <= StFix;
                        end
                    end
                    StFix: begin
                        if (is_div_q) begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end else begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign busy = state_q != StIdle;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
